// File: rtl/vpi_mem_pkg.sv
// Shared types and the fill pattern for the externally accessible memory test block.
package vpi_mem_pkg;

  typedef enum logic {
    OP_FILL  = 1'b0,
    OP_CHECK = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  // The pattern is computed at this fixed width and truncated by the caller,
  // so data widths up to 64 bits are supported.
  localparam int unsigned PATTERN_W = 64;

  // Expected word at an index: index plus seed, wrapping at the data width.
  function automatic logic [PATTERN_W-1:0] exp_word(input logic [PATTERN_W-1:0] idx,
                                                    input logic [PATTERN_W-1:0] seed);
    return idx + seed;
  endfunction

endpackage

// File: rtl/vpi_mem_array.sv
// Memory array for the fill/check block. Entries 1..DEPTH are visible to an
// external agent; one write port for the fill walk and one registered read
// port that is shared between the check walk and the RTL-side read request.
module vpi_mem_array
  import vpi_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             chk_en_i,
  input  logic [AW-1:0]    chk_idx_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_idx_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [1:DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             sel_en;
  logic [AW-1:0]    sel_idx;

  // The check walk owns the read port while it runs; otherwise the request port does.
  always_comb begin
    sel_en  = chk_en_i | rd_en_i;
    sel_idx = chk_en_i ? chk_idx_i : rd_idx_i;
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_idx_i] <= wr_data_i;
    end
  end

  // Registered read, so data appears the cycle after the select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (sel_en) begin
      rdata_q <= mem[sel_idx];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vpi_mem_fill_check.sv
// Writer side of the memory-access test: fills the array with index+seed from
// the top index down, re-checks it on request to catch external writes, and
// serves a single-word read port while idle.
module vpi_mem_fill_check
  import vpi_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int IW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_seed,
  output logic             cmd_ready,
  output logic             done,
  output logic [IW-1:0]    err_count,
  output logic [IW-1:0]    first_err_idx,
  input  logic             rd_req,
  input  logic [IW-1:0]    rd_idx,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_oob
);

  localparam int AW = $clog2(DEPTH + 1);

  state_e           state_q;
  logic [IW-1:0]    ptr_q;
  logic [WIDTH-1:0] seed_q;
  logic             cmd_ready_q;
  logic             done_q;
  logic [IW-1:0]    err_count_q;
  logic [IW-1:0]    err_count_d;
  logic [IW-1:0]    first_err_idx_q;
  logic [IW-1:0]    first_err_idx_d;
  logic             rd_ack_q;
  logic             rd_oob_q;
  logic             chk_v_q;
  logic [IW-1:0]    chk_idx_q;

  logic             cmd_accept;
  logic             rd_accept;
  logic             rd_inrange;
  logic             fill_we;
  logic             chk_rd;
  logic             chk_mismatch;
  logic [WIDTH-1:0] fill_word;
  logic [WIDTH-1:0] chk_word;
  logic [WIDTH-1:0] mem_rdata;

  // Pattern word for an index under a seed, truncated to the data width.
  function automatic logic [WIDTH-1:0] pattern(input logic [IW-1:0] idx,
                                               input logic [WIDTH-1:0] seed);
    logic [PATTERN_W-1:0] full;
    full = exp_word(PATTERN_W'(idx), PATTERN_W'(seed));
    return full[WIDTH-1:0];
  endfunction

  // Handshakes, walk controls and the checker compare for the current cycle.
  always_comb begin
    cmd_accept   = (state_q == S_IDLE) && cmd_valid;
    rd_accept    = (state_q == S_IDLE) && rd_req && !cmd_valid;
    rd_inrange   = (rd_idx != '0) && (rd_idx <= IW'(DEPTH));
    fill_we      = (state_q == S_FILL);
    chk_rd       = (state_q == S_CHECK) && (ptr_q != '0);
    fill_word    = pattern(ptr_q, seed_q);
    chk_word     = pattern(chk_idx_q, seed_q);
    chk_mismatch = chk_v_q && (mem_rdata != chk_word);
  end

  // Error bookkeeping: saturating count, and the first (highest) bad index.
  always_comb begin
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    if (chk_mismatch) begin
      if (err_count_q != {IW{1'b1}}) begin
        err_count_d = err_count_q + IW'(1);
      end
      if (err_count_q == '0) begin
        first_err_idx_d = chk_idx_q;
      end
    end
  end

  // Control FSM with registered handshake, status and read-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= '0;
      seed_q          <= '0;
      cmd_ready_q     <= 1'b1;
      done_q          <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      rd_ack_q        <= 1'b0;
      rd_oob_q        <= 1'b0;
      chk_v_q         <= 1'b0;
      chk_idx_q       <= '0;
    end else begin
      done_q          <= 1'b0;
      rd_ack_q        <= rd_accept;
      rd_oob_q        <= rd_accept && !rd_inrange;
      chk_v_q         <= chk_rd;
      chk_idx_q       <= ptr_q;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;

      case (state_q)
        S_IDLE: begin
          if (cmd_accept) begin
            seed_q      <= cmd_seed;
            ptr_q       <= IW'(DEPTH);
            cmd_ready_q <= 1'b0;
            if (op_e'(cmd_op) == OP_CHECK) begin
              state_q         <= S_CHECK;
              err_count_q     <= '0;
              first_err_idx_q <= '0;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          ptr_q <= ptr_q - IW'(1);
          if (ptr_q == IW'(1)) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (ptr_q != '0) begin
            ptr_q <= ptr_q - IW'(1);
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  vpi_mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fill_we),
    .wr_idx_i  (ptr_q[AW-1:0]),
    .wr_data_i (fill_word),
    .chk_en_i  (chk_rd),
    .chk_idx_i (ptr_q[AW-1:0]),
    .rd_en_i   (rd_accept && rd_inrange),
    .rd_idx_i  (rd_idx[AW-1:0]),
    .rdata_o   (mem_rdata)
  );

  assign cmd_ready     = cmd_ready_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign rd_ack        = rd_ack_q;
  assign rd_oob        = rd_oob_q;
  assign rd_data       = (rd_ack_q && !rd_oob_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_vpi_mem_fill_check.sv
// Self-checking bench for vpi_mem_fill_check: directed scenarios plus random
// fill/corrupt/check rounds against an array model of the memory.
module tb_vpi_mem_fill_check;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int IW    = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_seed;
  logic             cmd_ready;
  logic             done;
  logic [IW-1:0]    err_count;
  logic [IW-1:0]    first_err_idx;
  logic             rd_req;
  logic [IW-1:0]    rd_idx;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_data;
  logic             rd_oob;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] model [1:DEPTH];

  vpi_mem_fill_check #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .IW    (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_seed      (cmd_seed),
    .cmd_ready     (cmd_ready),
    .done          (done),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .rd_req        (rd_req),
    .rd_idx        (rd_idx),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_oob        (rd_oob)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Last-resort guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected memory word straight from the pattern rule.
  function automatic logic [WIDTH-1:0] refWord(input int idx, input logic [WIDTH-1:0] seed);
    logic [WIDTH-1:0] i;
    i = idx;
    return i + seed;
  endfunction

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks the read response for an index issued one cycle earlier.
  task automatic checkRead(input int idx);
    bit inRange;
    inRange = (idx >= 1) && (idx <= DEPTH);
    checkOutput($sformatf("rd_ack_%0d", idx), rd_ack, 1);
    checkOutput($sformatf("rd_oob_%0d", idx), rd_oob, inRange ? 0 : 1);
    checkOutput($sformatf("rd_data_%0d", idx), rd_data, inRange ? model[idx] : 0);
  endtask

  // Single read once the block is idle.
  task automatic doRead(input int idx);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rd_req = 1'b1;
    rd_idx = idx[IW-1:0];
    @(negedge clk);
    rd_req = 1'b0;
    checkRead(idx);
  endtask

  // Issues one command, follows it to done and checks latency and results.
  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] seed, input bit watchRd,
                               output int waitCyc, output int latency);
    int expErr;
    int expFirst;
    waitCyc   = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seed  = seed;
    while (!cmd_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_seed  = $urandom;
    latency   = 1;
    if (watchRd) checkOutput("rd_ignored", rd_ack, 0);
    while (!done && latency < 100) begin
      @(negedge clk);
      latency++;
      if (watchRd) checkOutput("rd_ignored", rd_ack, 0);
    end
    checkOutput("done_seen", done, 1);
    checkOutput("busy_at_done", cmd_ready, 0);
    if (op == 1'b0) begin
      checkOutput("fill_latency", latency, DEPTH + 1);
      for (int i = 1; i <= DEPTH; i++) model[i] = refWord(i, seed);
    end else begin
      checkOutput("check_latency", latency, DEPTH + 2);
      expErr   = 0;
      expFirst = 0;
      for (int i = DEPTH; i >= 1; i--) begin
        if (model[i] !== refWord(i, seed)) begin
          if (expErr == 0) expFirst = i;
          expErr++;
        end
      end
      checkOutput("err_count", err_count, expErr);
      checkOutput("first_err_idx", first_err_idx, expFirst);
    end
  endtask

  // Directed scenarios followed by random rounds.
  initial begin
    int               w1, lat1, w2, lat2, n, idx, prevIdx;
    logic [WIDTH-1:0] s, s2, v;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_seed  = '0;
    rd_req    = 1'b0;
    rd_idx    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_first_err", first_err_idx, 0);
    checkOutput("reset_rd_ack", rd_ack, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_rd_oob", rd_oob, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with seed 0: every entry equals its index.
    applyStimulus(1'b0, 32'h0, 1'b0, w1, lat1);
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput($sformatf("mem_seed0_%0d", i), dut.u_array.mem[i], i);
    end
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("ready_after_fin", cmd_ready, 1);
    doRead(5);
    checkOutput("rd_data_five", rd_data, 5);

    // Wrapping seed, then an immediate check with the same seed.
    applyStimulus(1'b0, 32'hFFFF_FFF0, 1'b0, w1, lat1);
    checkOutput("mem16_wrap", dut.u_array.mem[16], 32'h0);
    checkOutput("mem1_wrap", dut.u_array.mem[1], 32'hFFFF_FFF1);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 1'b0, w2, lat2);
    checkOutput("b2b_wait", w2, 1);
    checkOutput("b2b_total", lat1 + w2 + lat2, 36);
    checkOutput("clean_err", err_count, 0);
    checkOutput("clean_first", first_err_idx, 0);

    // External corruption caught by CHECK.
    applyStimulus(1'b0, 32'h0, 1'b0, w1, lat1);
    @(negedge clk);
    dut.u_array.mem[3]  = 32'd99;
    model[3]            = 32'd99;
    dut.u_array.mem[12] = 32'd7;
    model[12]           = 32'd7;
    applyStimulus(1'b1, 32'h0, 1'b0, w2, lat2);
    checkOutput("corrupt_err", err_count, 2);
    checkOutput("corrupt_first", first_err_idx, 12);

    // Out-of-range reads.
    @(negedge clk);
    doRead(0);
    doRead(DEPTH + 1);

    // Read held with a command in idle and throughout a fill: never acknowledged.
    rd_req = 1'b1;
    rd_idx = 9'd5;
    applyStimulus(1'b0, $urandom, 1'b1, w1, lat1);
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput("rd_ignored_fin", rd_ack, 0);

    // Reset five cycles into a fill.
    s         = $urandom;
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_seed  = s;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ready", cmd_ready, 1);
    checkOutput("midreset_done", done, 0);
    for (int i = DEPTH - 4; i <= DEPTH; i++) model[i] = refWord(i, s);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput($sformatf("mem_partial_%0d", i), dut.u_array.mem[i], model[i]);
    end
    applyStimulus(1'b0, $urandom, 1'b0, w1, lat1);

    // Random fill / corrupt / check rounds with back-to-back reads.
    for (int r = 0; r < 6; r++) begin
      s = $urandom;
      applyStimulus(1'b0, s, 1'b0, w1, lat1);
      @(negedge clk);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        idx = $urandom_range(1, DEPTH);
        v   = $urandom;
        dut.u_array.mem[idx] = v;
        model[idx]           = v;
      end
      s2 = ($urandom_range(0, 3) == 0) ? $urandom : s;
      applyStimulus(1'b1, s2, 1'b0, w2, lat2);
      @(negedge clk);
      prevIdx = $urandom_range(0, DEPTH + 2);
      rd_req  = 1'b1;
      rd_idx  = prevIdx[IW-1:0];
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checkRead(prevIdx);
        if (k < 4) begin
          prevIdx = $urandom_range(0, DEPTH + 2);
          rd_idx  = prevIdx[IW-1:0];
        end else begin
          rd_req = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vpi_mem_fill_check.md
Name: vpi_mem_fill_check

Overview:
- Owns a DEPTH-entry memory (index range 1..DEPTH) marked public_flat_rw @(posedge clk), so a VPI/DPI agent can read or write it directly.
- On command it fills the array with a known pattern, walking from DEPTH down to 1; the external agent then reads and checks it. This is the writer side of the memory-access test.
- It can also re-check the array against the pattern, to catch external writes. It serves a simple single-word read port for RTL-side inspection.

Parameters:
- DEPTH, 16, number of entries; legal range 2..256; index range 1..DEPTH.
- WIDTH, 32, data width in bits.
- IW, 9, index width; must satisfy DEPTH < 2**IW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  1  0 = FILL, 1 = CHECK.
- cmd_seed  in  WIDTH  pattern offset; captured when a command is accepted.
- cmd_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err_count  out  IW  mismatches found by the last CHECK.
- first_err_idx  out  IW  index of the first mismatch; 0 if there was none.
- rd_req  in  1  read request; accepted only in IDLE.
- rd_idx  in  IW  read index.
- rd_ack  out  1  one-cycle pulse, one cycle after an accepted rd_req.
- rd_data  out  WIDTH  read data; valid while rd_ack is high.
- rd_oob  out  1  high with rd_ack when rd_idx was outside 1..DEPTH (rd_data = 0).

Behaviour:
- Reset values of outputs: cmd_ready = 1, done = 0, err_count = 0, first_err_idx = 0, rd_ack = 0, rd_data = 0, rd_oob = 0. Reset also sets state to IDLE. Memory contents are not reset.
- Pattern: exp(i) = i + seed, computed modulo 2**WIDTH; i is zero-extended to WIDTH.
- FSM states: IDLE, FILL, CHECK, FIN.
- IDLE:
  - A command is accepted when cmd_valid is high (cmd_ready is high by definition).
  - On acceptance: capture seed, set ptr = DEPTH, go to FILL or CHECK.
  - If rd_req and cmd_valid are high in the same cycle, the command wins and rd_req is dropped (no rd_ack).
- FILL:
  - Each cycle: mem[ptr] <= exp(ptr), then ptr decrements.
  - The write at ptr = 1 is the last one; the next state is FIN.
  - Duration: exactly DEPTH cycles.
- CHECK:
  - Registered read of mem[ptr], so the compare happens one cycle later. Requires a 1-cycle valid pipe stage carrying the index.
  - Total CHECK duration: DEPTH + 1 cycles.
  - CHECK clears err_count and first_err_idx when it is accepted.
  - Each mismatch increments err_count, saturating at 2**IW - 1.
  - first_err_idx records the first mismatching index in walk order, i.e. the highest index.
  - Compare is 2-state (!= on known bits).
- FIN: done = 1 for exactly one cycle, then IDLE. cmd_ready is 0 throughout FILL, CHECK and FIN.
- Read port:
  - An accepted rd_req in IDLE gives rd_ack plus rd_data the next cycle.
  - rd_req outside IDLE is ignored (no ack).
  - Back-to-back requests give back-to-back acks.
- External VPI writes during FILL: last writer wins per simulator ordering; not guaranteed. The bench writes only in IDLE.
- Reset asserted mid-FILL/CHECK: immediate return to IDLE, outputs at reset values, memory partially filled; no done pulse.
- A new command in the cycle after done is accepted (FIN→IDLE takes one cycle, so the earliest acceptance is two cycles after the last FILL write).

Decomposition:
- Package vpi_mem_pkg:
  - op_e enum {OP_FILL = 1'b0, OP_CHECK = 1'b1}.
  - state_e enum {S_IDLE, S_FILL, S_CHECK, S_FIN}.
  - Function exp_word(idx, seed).
- Sub-module vpi_mem_array: the public_flat_rw memory with one write port and one registered read port, with a read-port mux between CHECK and rd_req. The top holds the FSM, counter and checker.

Test Plan:
- FILL, seed 0, DEPTH = 16 → done exactly 16 cycles after acceptance (+1 FIN). The external DPI reader sees mem[i] == i for i = 16..1. rd_req idx 5 → rd_data = 5 next cycle.
- FILL, seed 32'hFFFF_FFF0 → mem[16] = 0 (wrap) and mem[1] = 32'hFFFF_FFF1. A following CHECK with the same seed → err_count = 0, first_err_idx = 0.
- FILL seed 0. DPI writes mem[3] = 99 and mem[12] = 7. CHECK seed 0 → err_count = 2, first_err_idx = 12.
- rd_req idx 0 and idx 17 → rd_ack with rd_oob = 1, rd_data = 0. rd_req during FILL → no rd_ack. rd_req together with cmd_valid in IDLE → command accepted, no ack.
- Assert rst_n low 5 cycles into a FILL → cmd_ready = 1 and done = 0 at once; mem[16..12] hold the pattern. A new FILL then completes normally.
- Back-to-back: CHECK issued the cycle after FILL's done → accepted in IDLE. Total error-free time is 16 + 1 + 1 + 17 + 1 cycles.
